sc_bus_skid_reg: RTL

//  Registered source stage directly upstream of the CC_BUS pass-through bus.

---
 rtl/sc_bus_skid_reg_pkg.sv | 18 +
 rtl/sc_bus_data_reg.sv | 39 +++
 rtl/sc_bus_skid_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sc_bus_skid_reg_pkg.sv
// Shared definitions for the CC_BUS source skid stage: state encodings,
// default bus width and a small state decode helper.
package sc_bus_skid_reg_pkg;

    localparam int DATAWIDTH_BUS_DEF = 32;

    typedef enum logic [1:0] {
        SC_BUSSKID_EMPTY = 2'd0,
        SC_BUSSKID_BUSY  = 2'd1,
        SC_BUSSKID_FULL  = 2'd2
    } skid_state_e;

    // A word sits on the bus output whenever the main register is occupied.
    function automatic logic state_has_word(skid_state_e s);
        return (s == SC_BUSSKID_BUSY) || (s == SC_BUSSKID_FULL);
    endfunction

endpackage

// File: rtl/sc_bus_data_reg.sv
// Data-word register with synchronous clear (priority) and load enable.
// Used twice by the skid stage: once as the bus-facing main register and
// once as the overflow skid register.
module sc_bus_data_reg #(
    parameter int DATAWIDTH_BUS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     load_i,
    input  logic [DATAWIDTH_BUS-1:0] data_i,
    output logic [DATAWIDTH_BUS-1:0] data_o
);

    logic [DATAWIDTH_BUS-1:0] data_q;
    logic [DATAWIDTH_BUS-1:0] data_d;

    // Next value: clear beats load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = data_i;
        end
    end

    // Storage flop, zeroed asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sc_bus_skid_reg.sv
// Registered source stage feeding the CC_BUS pass-through bus. A main
// register drives the bus, a skid register absorbs the one word that can
// arrive after the consumer stalls, so the upstream ready stays a flop
// while still sustaining one word per cycle.
module sc_bus_skid_reg
    import sc_bus_skid_reg_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF
) (
    input  logic                     SC_BUSSKID_CLOCK_50,
    input  logic                     SC_BUSSKID_RESET_InLow,
    input  logic                     SC_BUSSKID_Clear_InLow,
    input  logic [DATAWIDTH_BUS-1:0] SC_BUSSKID_Data_In,
    input  logic                     SC_BUSSKID_Valid_In,
    output logic                     SC_BUSSKID_Ready_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_BUSSKID_DataBUS_Out,
    output logic                     SC_BUSSKID_Valid_Out,
    input  logic                     SC_BUSSKID_Ready_In,
    output logic [1:0]               SC_BUSSKID_Count_Out
);

    skid_state_e              state_q;
    skid_state_e              state_d;
    logic                     ready_q;
    logic                     ready_d;
    logic                     valid_w;
    logic                     in_xfer_w;
    logic                     out_xfer_w;
    logic                     clear_w;
    logic                     main_load_w;
    logic                     main_from_skid_w;
    logic                     skid_load_w;
    logic [DATAWIDTH_BUS-1:0] main_data_w;
    logic [DATAWIDTH_BUS-1:0] main_q_w;
    logic [DATAWIDTH_BUS-1:0] skid_q_w;

    assign clear_w    = ~SC_BUSSKID_Clear_InLow;
    assign valid_w    = state_has_word(state_q);
    assign in_xfer_w  = SC_BUSSKID_Valid_In & ready_q;
    assign out_xfer_w = valid_w & SC_BUSSKID_Ready_In;

    // Next-state, register load strobes and next ready; clear overrides all.
    always_comb begin
        state_d          = state_q;
        main_load_w      = 1'b0;
        main_from_skid_w = 1'b0;
        skid_load_w      = 1'b0;
        unique case (state_q)
            SC_BUSSKID_EMPTY: begin
                if (in_xfer_w) begin
                    main_load_w = 1'b1;
                    state_d     = SC_BUSSKID_BUSY;
                end
            end
            SC_BUSSKID_BUSY: begin
                if (in_xfer_w && out_xfer_w) begin
                    main_load_w = 1'b1;
                end else if (in_xfer_w) begin
                    skid_load_w = 1'b1;
                    state_d     = SC_BUSSKID_FULL;
                end else if (out_xfer_w) begin
                    state_d = SC_BUSSKID_EMPTY;
                end
            end
            SC_BUSSKID_FULL: begin
                if (SC_BUSSKID_Ready_In) begin
                    main_load_w      = 1'b1;
                    main_from_skid_w = 1'b1;
                    state_d          = SC_BUSSKID_BUSY;
                end
            end
            default: begin
                state_d = SC_BUSSKID_EMPTY;
            end
        endcase
        if (clear_w) begin
            state_d          = SC_BUSSKID_EMPTY;
            main_load_w      = 1'b0;
            main_from_skid_w = 1'b0;
            skid_load_w      = 1'b0;
        end
        ready_d = (state_d != SC_BUSSKID_FULL);
    end

    // State and registered upstream ready.
    always_ff @(posedge SC_BUSSKID_CLOCK_50 or negedge SC_BUSSKID_RESET_InLow) begin
        if (!SC_BUSSKID_RESET_InLow) begin
            state_q <= SC_BUSSKID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    assign main_data_w = main_from_skid_w ? skid_q_w : SC_BUSSKID_Data_In;

    sc_bus_data_reg #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_main_reg (
        .clk_i   (SC_BUSSKID_CLOCK_50),
        .rst_n_i (SC_BUSSKID_RESET_InLow),
        .clr_i   (clear_w),
        .load_i  (main_load_w),
        .data_i  (main_data_w),
        .data_o  (main_q_w)
    );

    sc_bus_data_reg #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_skid_reg (
        .clk_i   (SC_BUSSKID_CLOCK_50),
        .rst_n_i (SC_BUSSKID_RESET_InLow),
        .clr_i   (clear_w),
        .load_i  (skid_load_w),
        .data_i  (SC_BUSSKID_Data_In),
        .data_o  (skid_q_w)
    );

    assign SC_BUSSKID_Ready_Out   = ready_q;
    assign SC_BUSSKID_Valid_Out   = valid_w;
    assign SC_BUSSKID_DataBUS_Out = main_q_w;
    assign SC_BUSSKID_Count_Out   = state_q;

endmodule
